// File: rtl/dla_walker_engine.sv
// Diffusion-limited-aggregation walker: seeds a pixel, spawns random walkers on the border
// and sticks them on contact with the aggregate. Define DLA_DIAG_NEIGHBOR_EN for 8-neighbour contact.
module dla_walker_engine #(
    parameter int X_W = 10,
    parameter int Y_W = 10,
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int DATA_W = 16,
    parameter logic [DATA_W-1:0] STICK_COLOR = '1,
    parameter int SEED_X = 320,
    parameter int SEED_Y = 240,
    parameter int MAX_WALKERS = 256,
    parameter logic [30:0] LFSR_SEED = 31'h1
) (
    input  logic                          iCLK,
    input  logic                          iRST_N,
    input  logic                          iStart,
    input  logic                          iPause,
    output logic                          oMem_Req,
    input  logic                          iMem_Gnt,
    output logic                          oMem_WE,
    output logic [X_W+Y_W-1:0]            oMem_Addr,
    output logic [DATA_W-1:0]             oMem_WData,
    input  logic [DATA_W-1:0]             iMem_RData,
    output logic                          oBusy,
    output logic                          oDone,
    output logic [$clog2(MAX_WALKERS+1)-1:0] oCount,
    output logic [X_W-1:0]                oWalk_X,
    output logic [Y_W-1:0]                oWalk_Y,
    output logic [3:0]                    oState
);
    // state  | meaning
    // IDLE   | waiting for iStart
    // SEED   | writing the seed pixel
    // SPAWN  | placing a new walker on a random border pixel
    // NREQ   | picking the next in-range neighbour, issuing its read
    // NWAIT  | waiting for grant and read data of that neighbour
    // DECIDE | branch on contact
    // STEP   | random diagonal step; leaving the area respawns
    // STICK  | writing the walker pixel, counting it
    // DONE   | all walkers stuck
    localparam logic [3:0] IDLE = 4'd0, SEED = 4'd1, SPAWN = 4'd2, NREQ = 4'd3, NWAIT = 4'd4,
                           DECIDE = 4'd5, STEP = 4'd6, STICK = 4'd7, DONE = 4'd8;

    localparam int CNT_W  = $clog2(MAX_WALKERS + 1);
    localparam int H_LAST = H_RES - 1;
    localparam int V_LAST = V_RES - 1;
    localparam int CNT_LAST_I = MAX_WALKERS - 1;
    localparam logic [X_W:0]     H_LIM  = H_RES[X_W:0];
    localparam logic [Y_W:0]     V_LIM  = V_RES[Y_W:0];
    localparam logic [X_W-1:0]   X_LAST = H_LAST[X_W-1:0];
    localparam logic [Y_W-1:0]   Y_LAST = V_LAST[Y_W-1:0];
    localparam logic [X_W-1:0]   SX     = SEED_X[X_W-1:0];
    localparam logic [Y_W-1:0]   SY     = SEED_Y[Y_W-1:0];
    localparam logic [X_W:0]     X_ONE  = 1;
    localparam logic [Y_W:0]     Y_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_LAST_I[CNT_W-1:0];
`ifdef DLA_DIAG_NEIGHBOR_EN
    localparam logic [2:0] NLAST = 3'd7;
`else
    localparam logic [2:0] NLAST = 3'd3;
`endif

    logic [3:0]        state;
    logic [30:0]       lfsr;
    logic [X_W-1:0]    walk_x;
    logic [Y_W-1:0]    walk_y;
    logic [2:0]        nidx;
    logic              hit, rd_pend, rd_valid;
    logic [DATA_W-1:0] rd_q;

    logic [X_W:0]      xm, xp, nbr_x, step_x;
    logic [Y_W:0]      ym, yp, nbr_y, step_y;
    logic              nbr_ok, nbr_last, step_ok, rd_ready, rd_hit;
    logic [X_W-1:0]    cx;
    logic [Y_W-1:0]    cy;

    // Neighbour and step arithmetic is one bit wider so -1 wraps above the limit.
    always_comb begin
        xm = {1'b0, walk_x} - X_ONE;
        xp = {1'b0, walk_x} + X_ONE;
        ym = {1'b0, walk_y} - Y_ONE;
        yp = {1'b0, walk_y} + Y_ONE;
        nbr_x = {1'b0, walk_x};
        nbr_y = {1'b0, walk_y};
        case (nidx)
            3'd0: nbr_y = ym;
            3'd1: nbr_x = xm;
            3'd2: nbr_x = xp;
            3'd3: nbr_y = yp;
            3'd4: begin nbr_x = xm; nbr_y = ym; end
            3'd5: begin nbr_x = xp; nbr_y = ym; end
            3'd6: begin nbr_x = xm; nbr_y = yp; end
            default: begin nbr_x = xp; nbr_y = yp; end
        endcase
        nbr_ok   = (nbr_x < H_LIM) && (nbr_y < V_LIM);
        nbr_last = (nidx == NLAST);
        step_x   = lfsr[3] ? xp : xm;
        step_y   = lfsr[4] ? yp : ym;
        step_ok  = (step_x < H_LIM) && (step_y < V_LIM);
        cx = ({1'b0, lfsr[X_W-1:0]} >= H_LIM) ? lfsr[X_W-1:0] - H_LIM[X_W-1:0] : lfsr[X_W-1:0];
        cy = ({1'b0, lfsr[Y_W-1:0]} >= V_LIM) ? lfsr[Y_W-1:0] - V_LIM[Y_W-1:0] : lfsr[Y_W-1:0];
        rd_ready = rd_pend | rd_valid;
        rd_hit   = ((rd_pend ? iMem_RData : rd_q) == STICK_COLOR);
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state      <= IDLE;
            lfsr       <= LFSR_SEED;
            walk_x     <= '0;
            walk_y     <= '0;
            nidx       <= '0;
            hit        <= 1'b0;
            rd_pend    <= 1'b0;
            rd_valid   <= 1'b0;
            rd_q       <= '0;
            oMem_Req   <= 1'b0;
            oMem_WE    <= 1'b0;
            oMem_Addr  <= '0;
            oMem_WData <= '0;
            oCount     <= '0;
        end else begin
            lfsr <= (lfsr == 31'd0) ? 31'd1 : {lfsr[29:0], lfsr[30] ^ lfsr[27]};
            // Handshake and read capture keep running while paused.
            if (oMem_Req && iMem_Gnt) begin
                oMem_Req <= 1'b0;
                if (!oMem_WE) rd_pend <= 1'b1;
            end
            if (rd_pend) begin
                rd_pend  <= 1'b0;
                rd_q     <= iMem_RData;
                rd_valid <= 1'b1;
            end
            if (!iPause) begin
                case (state)
                    IDLE, DONE: if (iStart) begin
                        oCount     <= '0;
                        oMem_Req   <= 1'b1;
                        oMem_WE    <= 1'b1;
                        oMem_Addr  <= {SX, SY};
                        oMem_WData <= STICK_COLOR;
                        state      <= SEED;
                    end
                    SEED: if (!oMem_Req || iMem_Gnt) state <= SPAWN;
                    SPAWN: begin
                        case (lfsr[1:0])
                            2'd0: begin walk_x <= cx;     walk_y <= '0;     end
                            2'd1: begin walk_x <= cx;     walk_y <= Y_LAST; end
                            2'd2: begin walk_x <= '0;     walk_y <= cy;     end
                            default: begin walk_x <= X_LAST; walk_y <= cy;  end
                        endcase
                        nidx  <= '0;
                        state <= NREQ;
                    end
                    NREQ: begin
                        if (nbr_ok) begin
                            oMem_Req  <= 1'b1;
                            oMem_WE   <= 1'b0;
                            oMem_Addr <= {nbr_x[X_W-1:0], nbr_y[Y_W-1:0]};
                            state     <= NWAIT;
                        end else if (nbr_last) begin
                            hit   <= 1'b0;
                            state <= DECIDE;
                        end else begin
                            nidx <= nidx + 3'd1;
                        end
                    end
                    NWAIT: if (rd_ready) begin
                        rd_valid <= 1'b0;
                        if (rd_hit || nbr_last) begin
                            hit   <= rd_hit;
                            state <= DECIDE;
                        end else begin
                            nidx  <= nidx + 3'd1;
                            state <= NREQ;
                        end
                    end
                    DECIDE: begin
                        if (hit) begin
                            oMem_Req   <= 1'b1;
                            oMem_WE    <= 1'b1;
                            oMem_Addr  <= {walk_x, walk_y};
                            oMem_WData <= STICK_COLOR;
                            state      <= STICK;
                        end else begin
                            state <= STEP;
                        end
                    end
                    STEP: begin
                        if (step_ok) begin
                            walk_x <= step_x[X_W-1:0];
                            walk_y <= step_y[Y_W-1:0];
                            nidx   <= '0;
                            state  <= NREQ;
                        end else begin
                            state <= SPAWN;
                        end
                    end
                    STICK: if (!oMem_Req || iMem_Gnt) begin
                        oCount <= oCount + CNT_ONE;
                        state  <= (oCount == CNT_LAST) ? DONE : SPAWN;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign oBusy   = (state >= SEED) && (state <= STICK);
    assign oDone   = (state == DONE);
    assign oWalk_X = walk_x;
    assign oWalk_Y = walk_y;
    assign oState  = state;
endmodule

// File: tb/tb_dla_walker_engine.sv
// Directed bench for dla_walker_engine (MAX_WALKERS=4) with a sparse pixel memory model
// and background monitors for address range, spawn placement and step size.
module tb_dla_walker_engine;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, pause = 1'b0;
    logic        gnt_en = 1'b1, gnt_rand = 1'b0, rnd_bit = 1'b0, gnt;
    logic [15:0] rdata = 16'h0;
    logic        req, we, busy, done;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [2:0]  count;
    logic [9:0]  walk_x;
    logic [9:0]  walk_y;
    logic [3:0]  state;

    int errors = 0, checks = 0;
    int range_bad = 0, spawn_bad = 0, spawn_cnt = 0, step_bad = 0, step_cnt = 0, reads = 0;
    bit mem [int];
    bit always_hit = 1'b0;
    logic [3:0] prev_state = 4'd0;
    logic [9:0] px = 10'd0, py = 10'd0;
    logic [19:0] seed_addr;

    always #5 clk = ~clk;
    assign gnt = gnt_rand ? rnd_bit : gnt_en;

    dla_walker_engine #(.MAX_WALKERS(4)) dut (
        .iCLK(clk), .iRST_N(rst_n), .iStart(start), .iPause(pause),
        .oMem_Req(req), .iMem_Gnt(gnt), .oMem_WE(we), .oMem_Addr(addr),
        .oMem_WData(wdata), .iMem_RData(rdata), .oBusy(busy), .oDone(done),
        .oCount(count), .oWalk_X(walk_x), .oWalk_Y(walk_y), .oState(state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Read data is valid only in the cycle after the grant; zero otherwise.
    always @(posedge clk) begin
        rdata <= 16'h0;
        if (rst_n && req && gnt) begin
            if (we) mem[int'(addr)] = 1'b1;
            else rdata <= (always_hit || mem.exists(int'(addr))) ? 16'hFFFF : 16'h0;
        end
    end

    always @(negedge clk) begin
        rnd_bit <= 1'($urandom_range(0, 1));
        if (req && (addr[19:10] >= 10'd640 || addr[9:0] >= 10'd480)) range_bad++;
        if (prev_state == 4'd3 && state == 4'd4) reads++;
        if (prev_state == 4'd2 && state == 4'd3) begin
            spawn_cnt++;
            if (!(walk_x == 10'd0 || walk_x == 10'd639 || walk_y == 10'd0 || walk_y == 10'd479))
                spawn_bad++;
        end
        if (prev_state == 4'd6 && state == 4'd3) begin
            step_cnt++;
            if (!((walk_x == px + 10'd1 || walk_x + 10'd1 == px) &&
                  (walk_y == py + 10'd1 || walk_y + 10'd1 == py)))
                step_bad++;
        end
        prev_state = state;
        px = walk_x;
        py = walk_y;
    end

    task automatic wait_state(input logic [3:0] s, input int limit, input string tag);
        int n = 0;
        while (state !== s && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(tag, state, s);
    endtask

    task automatic wait_read(input int limit, input string tag);
        int n = 0;
        while (!(req === 1'b1 && we === 1'b0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, req & ~we}, 32'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [19:0] a0;
        logic [9:0]  x0, y0;
        int stable_bad, rd0;
        logic [2:0] cnt0;
        seed_addr = {10'd320, 10'd240};

        repeat (3) @(negedge clk);
        check("rst_state", state, 4'd0);
        check("rst_req", req, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_count", count, 3'd0);
        check("rst_addr", addr, 20'd0);
        check("rst_wdata", wdata, 16'h0);
        check("rst_walk", {walk_x, walk_y}, 20'd0);

        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("seed_state", state, 4'd1);
        check("seed_busy", busy, 1'b1);
        check("seed_req", {req, we}, 2'b11);
        check("seed_addr", addr, seed_addr);
        check("seed_wdata", wdata, 16'hFFFF);

        gnt_rand = 1'b1;
        repeat (5000) @(negedge clk);
        gnt_rand = 1'b0;
        check("spawns_seen", {31'd0, spawn_cnt > 0}, 32'd1);
        check("steps_seen", {31'd0, step_cnt > 0}, 32'd1);
        check("reads_seen", {31'd0, reads > 0}, 32'd1);

        // Hold grant low across a read, then let that single read hit.
        gnt_en = 1'b0;
        wait_read(300, "hold_read_found");
        a0 = addr;
        stable_bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (req !== 1'b1 || we !== 1'b0 || addr !== a0 || state !== 4'd4) stable_bad++;
        end
        check("hold_stable", stable_bad, 0);
        always_hit = 1'b1;
        rd0 = reads;
        gnt_en = 1'b1;
        wait_state(4'd7, 50, "hit_to_stick");
        check("hit_one_read", reads - rd0, 0);
        check("stick_we", {req, we}, 2'b11);
        check("stick_addr", addr, {walk_x, walk_y});
        check("stick_wdata", wdata, 16'hFFFF);
        cnt0 = count;
        @(negedge clk);
        check("stick_count", count, cnt0 + 3'd1);

        wait_state(4'd8, 3000, "reach_done");
        check("done_count", count, 3'd4);
        check("done_flag", done, 1'b1);
        check("done_busy", busy, 1'b0);
        repeat (5) @(negedge clk);
        check("done_hold", {done, state}, {1'b1, 4'd8});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_count", count, 3'd0);
        check("restart_state", {done, busy, state}, {1'b0, 1'b1, 4'd1});
        always_hit = 1'b0;

        wait_state(4'd6, 2000, "reach_step");
        pause = 1'b1;
        x0 = walk_x;
        y0 = walk_y;
        repeat (50) @(negedge clk);
        check("pause_xy", {walk_x, walk_y}, {x0, y0});
        check("pause_state", state, 4'd6);
        pause = 1'b0;
        @(negedge clk);
        check("unpause_moves", {31'd0, state == 4'd3 || state == 4'd2}, 32'd1);

        gnt_en = 1'b0;
        wait_read(300, "rst_read_found");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_ignored", {req, state}, {1'b1, 4'd4});
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_req", {req, we}, 2'b00);
        check("async_rst_state", state, 4'd0);
        check("async_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        gnt_en = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", {req, state}, {1'b0, 4'd0});

        check("addr_range", range_bad, 0);
        check("spawn_edge", spawn_bad, 0);
        check("step_diag", step_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
